// File: rtl/sysref_gen.sv
// ---------------------------------------------------------------------------
// sysref_gen -- periodic / burst SYSREF generator with per-output gating.
//
// An internal reference square wave (ref_r) is produced with each half
// lasting (hp_r + 1) aclk cycles.  The half length is shadowed from
// half_period_i at the start of the run and reloaded at every half boundary,
// so a new value takes effect cleanly on the next half.  In continuous mode
// the wave runs until the mode is dropped; it always finishes on the end of
// a low half, so no runt pulse is produced.  In burst mode exactly
// burst_len_i full periods are emitted, then done_o pulses.
//
// Ports:
//   aclk           in   1          sole clock, rising edge
//   aresetn        in   1          asynchronous active-low reset
//   half_period_i  in   CNT_WIDTH  half-period length minus 1 (cycles)
//   mode_i         in   2          00 off, 01 continuous, 10 burst, 11 off
//   burst_len_i    in   BURST_WIDTH full periods per burst
//   start_i        in   1          single-cycle burst start
//   sync_i         in   1          phase restart (ref forced low)
//   out_en_i       in   NUM_OUT    per-output enable mask
//   sysref_o       out  NUM_OUT    gated SYSREF outputs
//   busy_o         out  1          high while not IDLE
//   done_o         out  1          one-cycle pulse at burst completion
//   edge_count_o   out  32         ref rising-edge counter (only when
//                                  SYSREF_GEN_EDGE_COUNT_EN is defined)
//
// Optional feature macro: SYSREF_GEN_EDGE_COUNT_EN
// ---------------------------------------------------------------------------
module sysref_gen #(
    parameter int CNT_WIDTH   = 8,
    parameter int BURST_WIDTH = 8,
    parameter int NUM_OUT     = 1
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [CNT_WIDTH-1:0]   half_period_i,
    input  logic [1:0]             mode_i,
    input  logic [BURST_WIDTH-1:0] burst_len_i,
    input  logic                   start_i,
    input  logic                   sync_i,
    input  logic [NUM_OUT-1:0]     out_en_i,
    output logic [NUM_OUT-1:0]     sysref_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef SYSREF_GEN_EDGE_COUNT_EN
    ,
    output logic [31:0]            edge_count_o
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CONT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    localparam logic [1:0] MODE_CONT  = 2'b01;
    localparam logic [1:0] MODE_BURST = 2'b10;

    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] BCNT_ONE = BURST_WIDTH'(1);

    logic [1:0]             state_r, state_s;
    logic                   ref_r, ref_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
    logic [CNT_WIDTH-1:0]   hp_r, hp_s;
    logic [BURST_WIDTH-1:0] bcnt_r, bcnt_s;
    logic [NUM_OUT-1:0]     en_r, en_s;
    logic [NUM_OUT-1:0]     sysref_r;
    logic                   done_r, done_s;
    logic                   sync_clr_s;
    logic                   launch_s;

`ifdef SYSREF_GEN_EDGE_COUNT_EN
    logic [31:0]            edge_cnt_r, edge_cnt_s;
`endif

    // Next-state logic: trigger decode, half-period counting, burst tally.
    always_comb begin
        state_s    = state_r;
        ref_s      = ref_r;
        cnt_s      = cnt_r;
        hp_s       = hp_r;
        bcnt_s     = bcnt_r;
        done_s     = 1'b0;
        sync_clr_s = 1'b0;
        launch_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // sync_i is deliberately ignored here.
                if (mode_i == MODE_CONT) begin
                    state_s  = ST_CONT;
                    launch_s = 1'b1;
                end else if ((mode_i == MODE_BURST) && start_i &&
                             (burst_len_i != '0)) begin
                    state_s  = ST_BURST;
                    launch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CONT: begin
                if (sync_i) begin
                    sync_clr_s = 1'b1;
                end else if (cnt_r == hp_r) begin
                    cnt_s = '0;
                    hp_s  = half_period_i;
                    // Only a completed low half may hand back to IDLE.
                    if (!ref_r && (mode_i != MODE_CONT)) begin
                        state_s = ST_IDLE;
                        ref_s   = 1'b0;
                    end else begin
                        ref_s = ~ref_r;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_BURST: begin
                if (sync_i) begin
                    sync_clr_s = 1'b1;
                end else if (cnt_r == hp_r) begin
                    cnt_s = '0;
                    hp_s  = half_period_i;
                    if (ref_r) begin
                        // High->low: one more full period emitted; saturate
                        // at the burst length so the tally never wraps.
                        ref_s = 1'b0;
                        if (bcnt_r < burst_len_i) begin
                            bcnt_s = bcnt_r + BCNT_ONE;
                        end else begin
                            bcnt_s = bcnt_r;
                        end
                    end else if (bcnt_r >= burst_len_i) begin
                        state_s = ST_IDLE;
                        ref_s   = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        ref_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_s = ST_IDLE;
                ref_s   = 1'b0;
                cnt_s   = '0;
                bcnt_s  = '0;
            end
        endcase

        if (launch_s) begin
            ref_s  = 1'b1;
            cnt_s  = '0;
            bcnt_s = '0;
            hp_s   = half_period_i;
        end else if (sync_clr_s) begin
            ref_s  = 1'b0;
            cnt_s  = '0;
            bcnt_s = '0;
        end else begin
            ref_s = ref_s;
        end

        // The mask is only sampled while ref is low so a high half is never cut.
        if (ref_r) begin
            en_s = en_r;
        end else begin
            en_s = out_en_i;
        end
    end

`ifdef SYSREF_GEN_EDGE_COUNT_EN
    // Rising-edge tally of ref; cleared by a running-state sync.
    always_comb begin
        edge_cnt_s = edge_cnt_r;
        if (sync_clr_s) begin
            edge_cnt_s = 32'd0;
        end else if (ref_s && !ref_r) begin
            edge_cnt_s = edge_cnt_r + 32'd1;
        end else begin
            edge_cnt_s = edge_cnt_r;
        end
    end

    // Edge counter register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            edge_cnt_r <= 32'd0;
        end else begin
            edge_cnt_r <= edge_cnt_s;
        end
    end

    assign edge_count_o = edge_cnt_r;
`endif

    // State and datapath registers; sysref is registered from next-state
    // values so it tracks ref and the mask in the same cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r  <= ST_IDLE;
            ref_r    <= 1'b0;
            cnt_r    <= '0;
            hp_r     <= '0;
            bcnt_r   <= '0;
            en_r     <= '0;
            sysref_r <= '0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            ref_r    <= ref_s;
            cnt_r    <= cnt_s;
            hp_r     <= hp_s;
            bcnt_r   <= bcnt_s;
            en_r     <= en_s;
            sysref_r <= {NUM_OUT{ref_s}} & en_s;
            done_r   <= done_s;
        end
    end

    assign sysref_o = sysref_r;
    assign done_o   = done_r;
    assign busy_o   = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sysref_gen.sv
// ---------------------------------------------------------------------------
// tb_sysref_gen -- self-checking bench for sysref_gen.
// A cycle-level reference model tracks the run kind, the output level and
// the cycles left in the current half; every cycle the DUT outputs are
// compared with it.  Directed scenarios add timing checks against constants.
// ---------------------------------------------------------------------------
module tb_sysref_gen;

    localparam int NO = 2;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [7:0]    half_period = 8'd0;
    logic [1:0]    mode = 2'b00;
    logic [7:0]    burst_len = 8'd0;
    logic          start = 1'b0;
    logic          sync = 1'b0;
    logic [NO-1:0] out_en = '0;
    logic [NO-1:0] sysref;
    logic          busy;
    logic          done;
`ifdef SYSREF_GEN_EDGE_COUNT_EN
    logic [31:0]   edge_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int            m_run = 0;      // 0 idle, 1 continuous, 2 burst
    bit            m_lvl = 1'b0;
    int            m_left = 0;     // cycles remaining in current half
    int            m_half = 0;     // length of current half in cycles
    int            m_pulses = 0;
    logic [NO-1:0] m_mask = '0;
    bit            m_done = 1'b0;
    logic [31:0]   m_edges = 32'd0;

    sysref_gen #(.CNT_WIDTH(8), .BURST_WIDTH(8), .NUM_OUT(NO)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .half_period_i (half_period),
        .mode_i        (mode),
        .burst_len_i   (burst_len),
        .start_i       (start),
        .sync_i        (sync),
        .out_en_i      (out_en),
        .sysref_o      (sysref),
        .busy_o        (busy),
        .done_o        (done)
`ifdef SYSREF_GEN_EDGE_COUNT_EN
        ,
        .edge_count_o  (edge_count)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_lvl = 1'b0; m_left = 0; m_half = 0; m_pulses = 0;
        m_mask = '0; m_done = 1'b0; m_edges = 32'd0;
    endtask

    // One rising edge of behaviour, using the inputs present at that edge.
    task automatic model_step();
        int hp1;
        bit old_lvl;
        hp1 = int'(half_period) + 1;
        if (!aresetn) begin
            model_reset();
            return;
        end
        old_lvl = m_lvl;
        m_done = 1'b0;
        if (m_run == 0) begin
            if (mode == 2'b01 || (mode == 2'b10 && start && burst_len != 8'd0)) begin
                m_run = (mode == 2'b01) ? 1 : 2;
                m_lvl = 1'b1; m_half = hp1; m_left = hp1; m_pulses = 0;
                m_edges = m_edges + 32'd1;
            end
        end else if (sync) begin
            m_lvl = 1'b0; m_left = m_half; m_pulses = 0; m_edges = 32'd0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_half = hp1; m_left = hp1;
                if (m_lvl) begin
                    m_lvl = 1'b0;
                    if (m_run == 2) m_pulses++;
                end else if (m_run == 1 && mode != 2'b01) begin
                    m_run = 0;
                end else if (m_run == 2 && m_pulses >= int'(burst_len)) begin
                    m_run = 0; m_done = 1'b1;
                end else begin
                    m_lvl = 1'b1;
                    m_edges = m_edges + 32'd1;
                end
            end
        end
        if (!old_lvl) m_mask = out_en;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_sysref"}, 32'(sysref), m_lvl ? 32'(m_mask) : 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'(m_run != 0));
        check_eq({tag, "_done"}, 32'(done), 32'(m_done));
`ifdef SYSREF_GEN_EDGE_COUNT_EN
        check_eq({tag, "_edges"}, edge_count, m_edges);
`endif
    endtask

    // Advance one clock, step the model, then compare away from the edge.
    task automatic tick();
        @(posedge aclk);
        model_step();
        #1;
        compare_all("cyc");
    endtask

    task automatic go_idle();
        mode = 2'b00; start = 1'b0; sync = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy && m_run == 0) break;
            tick();
        end
        check_eq("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int hi, rises, second_rise, k;
        logic prev;

        // Reset state
        #1;
        check_eq("rst_sysref", 32'(sysref), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        tick(); tick();
        aresetn = 1'b1;
        tick();

        // Continuous mode: 48-cycle period, 24 high, first high right away
        half_period = 8'd23; out_en = 2'b01; mode = 2'b01;
        tick();
        check_eq("cont_first_high", 32'(sysref[0]), 32'd1);
        hi = 0; rises = 0; second_rise = 0; prev = 1'b0;
        for (int s = 1; s <= 96; s++) begin
            if (s > 1) tick();
            if (sysref[0]) hi++;
            if (sysref[0] && !prev) begin
                rises++;
                if (rises == 2) second_rise = s;
            end
            prev = sysref[0];
        end
        check_eq("cont_high_cycles", 32'(hi), 32'd48);
        check_eq("cont_period", 32'(second_rise), 32'd49);
        check_eq("cont_bit1_masked_off", 32'(sysref[1]), 32'd0);
        go_idle();

        // Burst: 3 pulses of 4 cycles, done 24 cycles after start
        half_period = 8'd3; burst_len = 8'd3; mode = 2'b10; start = 1'b1; out_en = 2'b11;
        tick();
        start = 1'b0;
        hi = 1; rises = 1; prev = sysref[0]; k = 0;
        for (int s = 1; s <= 60; s++) begin
            tick();
            if (sysref[0]) hi++;
            if (sysref[0] && !prev) rises++;
            prev = sysref[0];
            if (done) begin k = s; break; end
        end
        check_eq("burst_done_latency", 32'(k), 32'd24);
        check_eq("burst_busy_fall", 32'(busy), 32'd0);
        check_eq("burst_pulses", 32'(rises), 32'd3);
        check_eq("burst_high_cycles", 32'(hi), 32'd12);
        tick();
        check_eq("burst_done_single", 32'(done), 32'd0);

        // Continuous stop mid-high: remaining high, full low, then IDLE
        half_period = 8'd5; mode = 2'b01; out_en = 2'b01;
        tick(); tick(); tick();
        mode = 2'b00;
        hi = 0; k = 0;
        for (int s = 1; s <= 40; s++) begin
            tick();
            if (sysref[0]) hi++;
            if (!busy) begin k = s; break; end
        end
        check_eq("stop_ticks_to_idle", 32'(k), 32'd10);
        check_eq("stop_tail_high", 32'(hi), 32'd3);

        // Sync mid-high: low next cycle, rising hp+1 cycles later
        half_period = 8'd4; mode = 2'b01;
        tick(); tick(); tick();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        check_eq("sync_low_next", 32'(sysref[0]), 32'd0);
`ifdef SYSREF_GEN_EDGE_COUNT_EN
        check_eq("sync_edges_cleared", edge_count, 32'd0);
`endif
        k = 0;
        for (int s = 1; s <= 20; s++) begin
            tick();
            if (sysref[0]) begin k = s; break; end
        end
        check_eq("sync_rise_delay", 32'(k), 32'd5);
        go_idle();

        // Mask dropped while high: high half completes, then stays low
        half_period = 8'd3; mode = 2'b01; out_en = 2'b01;
        tick(); tick();
        out_en = 2'b00;
        tick(); tick();
        check_eq("mask_hold_high", 32'(sysref[0]), 32'd1);
        tick();
        check_eq("mask_low_after", 32'(sysref[0]), 32'd0);
        hi = 0;
        for (int s = 0; s < 16; s++) begin
            tick();
            if (sysref[0]) hi++;
        end
        check_eq("mask_stays_low", 32'(hi), 32'd0);
        out_en = 2'b11;
        go_idle();

        // Reset mid-burst: outputs clear at once, no done pulse
        half_period = 8'd2; burst_len = 8'd4; mode = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #2 aresetn = 1'b0;
        #1;
        model_reset();
        check_eq("arst_sysref", 32'(sysref), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        tick(); tick();
        aresetn = 1'b1;
        k = 0;
        for (int s = 0; s < 40; s++) begin
            tick();
            if (done || busy) k++;
        end
        check_eq("arst_no_restart", 32'(k), 32'd0);

        // Zero-length burst request stays idle
        burst_len = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("zero_len_idle", 32'(busy), 32'd0);
        tick();

        // Randomized traffic against the model
        mode = 2'b00; burst_len = 8'd2; half_period = 8'd1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(39, 0) == 0) mode = 2'($urandom_range(3, 0));
            if (m_run == 0 && !busy && $urandom_range(29, 0) == 0)
                burst_len = 8'($urandom_range(4, 0));
            if ($urandom_range(24, 0) == 0) half_period = 8'($urandom_range(6, 0));
            if ($urandom_range(19, 0) == 0) out_en = NO'($urandom);
            start = ($urandom_range(7, 0) == 0);
            sync = ($urandom_range(59, 0) == 0);
            tick();
        end
        start = 1'b0; sync = 1'b0;
        go_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
